// File: rtl/chunked_add_pkg.sv
// rtl/chunked_add_pkg.sv - shared state encoding and default sizes for the chunked adder
package chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/cla_chunk.sv
// rtl/cla_chunk.sv - combinational CHUNK-bit carry-lookahead adder slice
module cla_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead: carry into bit i+1 is built from generate/propagate terms directly.
  function automatic logic carry_at(input logic [CHUNK-1:0] gg, input logic [CHUNK-1:0] pp,
                                    input logic ci, input int i);
    logic acc;
    logic run;
    acc = gg[i];
    run = pp[i];
    for (int j = i - 1; j >= 0; j--) begin
      acc = acc | (run & gg[j]);
      run = run & pp[j];
    end
    return acc | (run & ci);
  endfunction

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_carry
    assign c[i+1] = carry_at(g, p, cin, i);
  end

  assign sum  = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_cla_adder.sv
// rtl/chunked_cla_adder.sv - multi-cycle adder summing one CHUNK per cycle with registered inter-chunk carry
module chunked_cla_adder
  import chunked_add_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int CHUNK         = DEF_CHUNK,
  parameter int APPROX_CHUNKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             approx_q;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH:0]   sum_q;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] cla_sum;
  logic [CHUNK-1:0] chunk_sum;
  logic             cla_cout;
  logic             chunk_cout;
  logic             approx_sel;
  logic             last;

  assign a_k        = a_q[int'(k)*CHUNK +: CHUNK];
  assign b_k        = b_q[int'(k)*CHUNK +: CHUNK];
  assign approx_sel = approx_q && (int'(k) < APPROX_CHUNKS);
  assign last       = (int'(k) == NCHUNK - 1);

  cla_chunk #(.CHUNK(CHUNK)) u_cla (
    .a    (a_k),
    .b    (b_k),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Approximate low chunks drop the incoming carry and only forward a guessed MSB carry.
  assign chunk_sum  = approx_sel ? (a_k | b_k) : cla_sum;
  assign chunk_cout = approx_sel ? (a_k[CHUNK-1] & b_k[CHUNK-1]) : cla_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      approx_q  <= 1'b0;
      k         <= '0;
      carry     <= 1'b0;
      sum_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            approx_q <= approx_en;
            carry    <= ci;
            k        <= '0;
            sum_q    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(k)*CHUNK +: CHUNK] <= chunk_sum;
          carry                         <= chunk_cout;
          if (last) begin
            sum_q[WIDTH] <= chunk_cout;
            k            <= '0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s = sum_q;

endmodule

// File: tb/tb_chunked_cla_adder.sv
// tb/tb_chunked_cla_adder.sv - directed self-checking bench for chunked_cla_adder
module tb_chunked_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        approx_en;
  logic        ci;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_ready;
  logic        out_valid;
  logic [16:0] s;
  logic        in_ready2;
  logic        out_valid2;
  logic [16:0] s2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chunked_cla_adder #(.WIDTH(16), .CHUNK(4), .APPROX_CHUNKS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  chunked_cla_adder #(.WIDTH(16), .CHUNK(4), .APPROX_CHUNKS(4)) dut_all (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .ci(ci), .approx_en(approx_en), .out_valid(out_valid2), .out_ready(out_ready), .s(s2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_txn(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic ci_i, input logic ax_i,
                         input logic [16:0] exp, input logic [16:0] exp_all);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = a_i; b = b_i; ci = ci_i; approx_en = ax_i; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); approx_en = 1'($urandom);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_s"}, 32'(s), 32'(exp));
    check({tag, "_s_all_approx"}, 32'(s2), 32'(exp_all));
    @(posedge clk);
    #1 check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset, with in_valid asserted alongside it: must not be accepted.
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; ci = 1'b1;
    approx_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1 check("reset_no_accept", 32'(in_ready), 32'd1);

    run_txn("ffff_p1",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 17'h10000);
    run_txn("ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 17'h1FFFF);
    run_txn("approx_00ff",  16'h00FF, 16'h0088, 1'b1, 1'b1, 17'h0018F, 17'h000FF);
    run_txn("exact_0f0f",   16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, 17'h01000);
    run_txn("approx_0f0f",  16'h0F0F, 16'h00F1, 1'b0, 1'b1, 17'h00FFF, 17'h00FFF);
    run_txn("approx_8421",  16'h8421, 16'h8C30, 1'b0, 1'b1, 17'h11051, 17'h18C31);

    // Back-pressure in DONE.
    @(negedge clk);
    a = 16'h00AA; b = 16'h0055; ci = 1'b0; approx_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    check("hold_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_s", 32'(s), 32'h000FF);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN aborts the transaction.
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_s", 32'(s), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    run_txn("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 17'h02345, 17'h02345);

    // New in_valid with different operands during RUN is ignored.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; ci = 1'b0; approx_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
    wait_out(lat);
    in_valid = 1'b0;
    check("ignore_latency", 32'(lat), 32'd4);
    check("ignore_s", 32'(s), 32'h00007);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("ignore_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
